fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS pipeline, directly upstream of Program_Memory.
//  Owns the PC register, drives the program-memory address, and computes next-PC:
//  sequential, branch, jump or redirect.
//  Captures the returned instruction into the IF/ID pipeline register with a valid bit.
//  Honours hazard-unit stall and flush; flags out-of-range or misaligned fetches.
// PARAMETERS
//  DATA_WIDTH    32            datapath / address width
//  MEMORY_DEPTH  32            program-memory depth in words; sets legal fetch window
//  RESET_PC      32'h0040_0000 PC value after reset; base of program memory
// PORTS
//  clk                 in   1   single clock; all state updates on rising edge
//  reset               in   1   synchronous, active-high reset
//  stall_i             in   1   hold PC and IF/ID contents (load-use hazard)
//  flush_i             in   1   load bubble into IF/ID (taken control transfer)
//  branch_taken_i      in   1   redirect PC to branch_target_i
//  branch_target_i     in   32  branch destination (byte address)
//  jump_i              in   1   redirect PC to jump_target_i (J/JAL/JR)
//  jump_target_i       in   32  jump destination (byte address)
//  instruction_i       in   32  combinational read data from Program_Memory
//  pc_o                out  32  current PC; wired to Program_Memory address_i
//  if_id_instruction_o out  32  registered instruction for decode
//  if_id_pc_plus4_o    out  32  registered PC+4 of that instruction
//  if_id_valid_o       out  1   1 = IF/ID holds a real instruction, 0 = bubble
//  fetch_fault_o       out  1   sticky: an illegal PC was fetched
//  fetch_count_o       out  32  number of valid instructions loaded into IF/ID
// BEHAVIOUR
//  Reset (sync, any cycle, including mid-stall or mid-redirect):
//    pc_o=RESET_PC, if_id_instruction_o=0 (NOP), if_id_pc_plus4_o=0,
//    if_id_valid_o=0, fetch_fault_o=0, fetch_count_o=0.
//  Next-PC priority per cycle, highest first:
//    reset > branch_taken_i > jump_i > stall_i > PC+4.
//    Redirect overrides stall: the PC loads the target even when stall_i=1.
//  IF/ID update priority: reset > flush_i > stall_i > load.
//    Redirect without flush_i still loads normally; the hazard unit owns flush.
//    load:  instr<=instruction_i, pc_plus4<=pc_o+4, valid<=~illegal(pc_o).
//    flush: instr<=0, pc_plus4<=0, valid<=0.
//    stall: all IF/ID fields hold.
//  Latency: an instruction at PC fetched in cycle N appears on IF/ID in cycle N+1.
//  Legal PC: RESET_PC <= pc < RESET_PC+4*MEMORY_DEPTH and pc[1:0]==0.
//    Illegal PC at a load edge sets fetch_fault_o (sticky until reset).
//    The IF/ID entry gets valid=0 and instr=0; the PC still advances.
//  Redirect targets are used as given; a misaligned target yields an illegal PC.
//  Arithmetic is modulo 2^32: PC+4 at 32'hFFFF_FFFC wraps to 0, which is illegal.
//  fetch_count_o increments only on a load with valid<=1; it wraps modulo 2^32.
//  Stall and flush asserted together: IF/ID flushes; PC holds unless redirected.
// STRUCTURE
//  mips_pkg holds:
//    RESET_PC_DEFAULT, NOP_INSTR=32'h0, INSTR_BYTES=4,
//    and function pc_legal(pc, base, depth).
//  One sub-module, if_id_register, holds instr, pc_plus4 and valid.
//    Ports: clk, reset, stall, flush, d/q.
//  PC register, next-PC mux, fault flag and counter stay in fetch_stage.
// TESTING
//  1. Reset, then 4 free-run cycles.
//     pc_o: 0x400000, 0x400004, 0x400008, 0x40000C.
//     IF/ID valid=1 from cycle 1; fetch_count_o=4.
//  2. stall_i=1 for 2 cycles at pc=0x400008.
//     pc_o and IF/ID hold; count frozen; fetch resumes at 0x40000C.
//  3. branch_taken_i=1 with target 0x400020, flush_i=1 in the same cycle.
//     Next pc_o=0x400020; IF/ID valid=0, instr=0; then the target instruction loads.
//  4. branch_taken_i=1 and jump_i=1 together.
//     Branch target wins; redirect with stall_i=1 still moves pc_o.
//  5. jump_target_i=0x400082 (misaligned) or 0x400080 (end of 32-word window).
//     fetch_fault_o=1 next edge and stays set; IF/ID valid=0; count unchanged.
//  6. reset asserted during a stall.
//     All outputs return to reset values on that edge; pc_o=0x400000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, IF/ID payload type and fetch-window check for the MIPS pipeline.
package mips_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0000_0000, valid: 1'b0};

    // Limit is computed 34 bits wide so a window near the top of the space cannot wrap.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
        logic [33:0] limit_s;
        limit_s  = {2'b00, base} + {depth, 2'b00};
        pc_legal = (pc >= base) && ({2'b00, pc} < limit_s) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid bit, with flush and stall.
module if_id_register
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Pipeline register update: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= IF_ID_BUBBLE;
        end else if (flush) begin
            q_r <= IF_ID_BUBBLE;
        end else if (stall) begin
            q_r <= q_r;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture,
// sticky illegal-fetch flag and a count of valid instructions delivered to decode.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  jump_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fetch_fault_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_next_s;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic                  illegal_s;
    logic                  load_s;
    logic                  fault_r;
    logic [DATA_WIDTH-1:0] count_r;
    if_id_t                if_id_d_s;
    if_id_t                if_id_q_s;

    assign pc_plus4_s = pc_r + INSTR_BYTES;
    assign illegal_s  = ~pc_legal(pc_r, RESET_PC, 32'(MEMORY_DEPTH));
    // A load edge is one where IF/ID takes a new entry; flush and stall both suppress it.
    assign load_s     = ~flush_i & ~stall_i;

    // Next-PC select: redirects beat stall, and branch beats jump.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (branch_taken_i) begin
            pc_next_s = branch_target_i;
        end else if (jump_i) begin
            pc_next_s = jump_target_i;
        end else if (stall_i) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // IF/ID payload; an illegal fetch becomes an invalid NOP entry.
    always_comb begin
        if_id_d_s          = IF_ID_BUBBLE;
        if_id_d_s.pc_plus4 = pc_plus4_s;
        if (illegal_s) begin
            if_id_d_s.instr = NOP_INSTR;
            if_id_d_s.valid = 1'b0;
        end else begin
            if_id_d_s.instr = instruction_i;
            if_id_d_s.valid = 1'b1;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Sticky fault flag and valid-load counter, both advanced only on load edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_r <= 1'b0;
            count_r <= 32'd0;
        end else if (load_s) begin
            if (illegal_s) begin
                fault_r <= 1'b1;
                count_r <= count_r;
            end else begin
                fault_r <= fault_r;
                count_r <= count_r + 32'd1;
            end
        end else begin
            fault_r <= fault_r;
            count_r <= count_r;
        end
    end

    if_id_register u_if_id (
        .clk   (clk),
        .reset (reset),
        .stall (stall_i),
        .flush (flush_i),
        .d     (if_id_d_s),
        .q     (if_id_q_s)
    );

    assign pc_o                = pc_r;
    assign if_id_instruction_o = if_id_q_s.instr;
    assign if_id_pc_plus4_o    = if_id_q_s.pc_plus4;
    assign if_id_valid_o       = if_id_q_s.valid;
    assign fetch_fault_o       = fault_r;
    assign fetch_count_o       = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random control
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = 32'd0;
    logic [31:0] instruction_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instruction_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit in_window(input logic [31:0] pc);
        if (pc % 4 != 0) return 0;
        if (pc < BASE) return 0;
        return ((pc - BASE) / 4) < DEPTH;
    endfunction

    assign instruction_i = mem_word(pc_o);

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .RESET_PC(BASE)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .branch_taken_i      (branch_taken_i),
        .branch_target_i     (branch_target_i),
        .jump_i              (jump_i),
        .jump_target_i       (jump_target_i),
        .instruction_i       (instruction_i),
        .pc_o                (pc_o),
        .if_id_instruction_o (if_id_instruction_o),
        .if_id_pc_plus4_o    (if_id_pc_plus4_o),
        .if_id_valid_o       (if_id_valid_o),
        .fetch_fault_o       (fetch_fault_o),
        .fetch_count_o       (fetch_count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc_o,                m_pc);
        check({tag, ".instr"}, if_id_instruction_o, m_instr);
        check({tag, ".pc4"},   if_id_pc_plus4_o,    m_pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, m_valid});
        check({tag, ".fault"}, {31'd0, fetch_fault_o}, {31'd0, m_fault});
        check({tag, ".count"}, fetch_count_o,       m_count);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step(input string tag);
        bit ok;
        @(posedge clk);
        if (reset) begin
            m_pc = BASE; m_instr = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0;
        end else begin
            ok = in_window(m_pc);
            if (flush_i) begin
                m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            end else if (!stall_i) begin
                m_instr = ok ? mem_word(m_pc) : 32'd0;
                m_pc4   = m_pc + 32'd4;
                m_valid = ok;
                if (ok) m_count = m_count + 32'd1;
                else    m_fault = 1'b1;
            end
            if (branch_taken_i)  m_pc = branch_target_i;
            else if (jump_i)     m_pc = jump_target_i;
            else if (!stall_i)   m_pc = m_pc + 32'd4;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step("reset");
        reset = 1'b0;
    endtask

    initial begin
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0;
        #2;
        do_reset();
        check("rst.pc_const", pc_o, 32'h0040_0000);

        // 1: free run
        for (int i = 0; i < 4; i++) step("run");
        check("run.count4", fetch_count_o, 32'd4);
        check("run.pc4", if_id_pc_plus4_o, 32'h0040_0010);

        // 2: stall at 0x400008
        do_reset();
        step("pre"); step("pre");
        check("stall.at", pc_o, 32'h0040_0008);
        stall_i = 1'b1;
        step("stall"); step("stall");
        check("stall.pc_hold", pc_o, 32'h0040_0008);
        stall_i = 1'b0;
        step("resume");
        check("resume.pc", pc_o, 32'h0040_000C);

        // 3: branch plus flush
        branch_taken_i = 1'b1; branch_target_i = 32'h0040_0020; flush_i = 1'b1;
        step("br_flush");
        check("br.pc", pc_o, 32'h0040_0020);
        check("br.bubble", {31'd0, if_id_valid_o}, 32'd0);
        idle_inputs();
        step("br_target");
        check("br.tgt_instr", if_id_instruction_o, mem_word(32'h0040_0020));

        // 4: branch beats jump, redirect beats stall
        branch_taken_i = 1'b1; branch_target_i = 32'h0040_0040;
        jump_i = 1'b1; jump_target_i = 32'h0040_0060; stall_i = 1'b1;
        step("br_vs_jmp");
        check("prio.pc", pc_o, 32'h0040_0040);
        idle_inputs();
        jump_i = 1'b1; stall_i = 1'b1;
        step("jmp_stall");
        check("jmp_stall.pc", pc_o, 32'h0040_0060);
        idle_inputs();
        step("after_jmp");

        // 5: misaligned and end-of-window jumps
        jump_i = 1'b1; jump_target_i = 32'h0040_0082;
        step("jmp_misal");
        idle_inputs();
        step("fault_mis");
        check("fault.mis", {31'd0, fetch_fault_o}, 32'd1);
        do_reset();
        jump_i = 1'b1; jump_target_i = 32'h0040_0080;
        step("jmp_end");
        idle_inputs();
        step("fault_end");
        check("fault.end", {31'd0, fetch_fault_o}, 32'd1);
        jump_i = 1'b1; jump_target_i = 32'h0040_007C;
        step("jmp_last");
        idle_inputs();
        step("last_ok");
        check("last.valid", {31'd0, if_id_valid_o}, 32'd1);
        check("fault.sticky", {31'd0, fetch_fault_o}, 32'd1);

        // wrap at the top of the address space
        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        step("jmp_top");
        idle_inputs();
        step("wrap");
        check("wrap.pc", pc_o, 32'h0000_0000);

        // 6: reset during stall
        stall_i = 1'b1;
        step("stall_pre");
        reset = 1'b1;
        step("rst_in_stall");
        check("rst6.pc", pc_o, 32'h0040_0000);
        reset = 1'b0; idle_inputs();
        step("post_rst");

        // random traffic
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(0, 79) == 0);
            stall_i        = ($urandom_range(0, 3) == 0);
            flush_i        = ($urandom_range(0, 5) == 0);
            branch_taken_i = ($urandom_range(0, 7) == 0);
            jump_i         = ($urandom_range(0, 7) == 0);
            branch_target_i = BASE + 32'd4 * 32'($urandom_range(0, 35));
            jump_target_i   = BASE + 32'd4 * 32'($urandom_range(0, 35));
            if ($urandom_range(0, 15) == 0) branch_target_i = branch_target_i + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) jump_target_i = jump_target_i + 32'($urandom_range(1, 3));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
